l2_line_responder: RTL and testbench

- Memory-side responder for the dcache-to-L2 line-transfer interface: serves LOAD line fills one word per beat and accepts STORE (writeback) words one per beat with a per-word acknowledge.
- Backed by an internal word-addressed storage array with fixed per-word access latency.
- Sits between the dcache controller/datapath and the rest of the memory model.
- Provides the STORE acknowledge the dcache flush path consumes to decrement its word counter.

---
 rtl/l2_line_responder.sv | 128 ++++++++++++
 tb/tb_l2_line_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_line_responder.sv
// Memory-side responder for dcache line transfers: LOAD fills and STORE writebacks,
// one word per LATENCY-cycle beat, highest word index first.
package l2_line_responder_pkg;
    typedef enum logic [1:0] {
        NOP   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } memory_operation_e;
endpackage

module l2_line_responder
    import l2_line_responder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_WORDS      = 1024,
    parameter int LATENCY        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l2_req_valid,
    input  memory_operation_e l2_req_type,
    input  logic [ADDR_W-1:0] l2_req_address,
    input  logic [WORD_W-1:0] l2_req_store_word,
    output logic [WORD_W-1:0] l2_fetched_word,
    output logic              l2_fetched_word_valid,
    output logic              l2_store_word_ack,
    output logic              busy
);

    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = IDX_W + 2;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STORE, ST_RELEASE} state_e;

    state_e            state, state_n;
    memory_operation_e op_q, op_n;
    logic [ADDR_W-1:0] base_q, base_n, req_base;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              beat_load, beat_store;
    logic [WORD_W-1:0] mem [MEM_WORDS];

    function automatic logic [MEM_AW-1:0] mem_index(input logic [ADDR_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
        logic [ADDR_W-1:0] sum;
        sum = (base >> 2) + ADDR_W'(idx);
        return MEM_AW'(sum);
    endfunction

    assign req_base = l2_req_address & LINE_MASK;
    assign busy     = (state != ST_IDLE);

    // cnt counts down to the beat cycle; a beat's pulse is registered on the edge
    // that enters the cycle where the counter reads zero.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        base_n  = base_q;
        idx_n   = idx_q;
        cnt_n   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (l2_req_valid && (l2_req_type == LOAD || l2_req_type == STORE)) begin
                    state_n = (l2_req_type == LOAD) ? ST_LOAD : ST_STORE;
                    op_n    = l2_req_type;
                    base_n  = req_base;
                    idx_n   = IDX_W'(WORDS_PER_LINE - 1);
                    cnt_n   = CNT_W'(LATENCY - 1);
                end
            end
            ST_LOAD, ST_STORE: begin
                if (!l2_req_valid)
                    state_n = ST_IDLE;
                else if (cnt_q != '0)
                    cnt_n = cnt_q - CNT_W'(1);
                else if (idx_q == '0)
                    state_n = ST_RELEASE;
                else begin
                    idx_n = idx_q - IDX_W'(1);
                    cnt_n = CNT_W'(LATENCY - 1);
                end
            end
            ST_RELEASE: begin
                // Wait for the requester to let go so a held request is not served twice.
                if (!l2_req_valid || l2_req_type != op_q || req_base != base_q)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        beat_load  = (state_n == ST_LOAD)  && (cnt_n == '0);
        beat_store = (state_n == ST_STORE) && (cnt_n == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            op_q                  <= NOP;
            base_q                <= '0;
            idx_q                 <= '0;
            cnt_q                 <= '0;
            l2_fetched_word       <= '0;
            l2_fetched_word_valid <= 1'b0;
            l2_store_word_ack     <= 1'b0;
        end else begin
            state                 <= state_n;
            op_q                  <= op_n;
            base_q                <= base_n;
            idx_q                 <= idx_n;
            cnt_q                 <= cnt_n;
            l2_fetched_word_valid <= beat_load;
            l2_store_word_ack     <= beat_store;
            if (beat_load)
                l2_fetched_word <= mem[mem_index(base_n, idx_n)];
        end
    end

    // Write lands at the end of the ack cycle; reset clears the ack so nothing lands after it.
    always_ff @(posedge clk) begin
        if (l2_store_word_ack)
            mem[mem_index(base_q, idx_q)] <= l2_req_store_word;
    end

endmodule

// File: tb/tb_l2_line_responder.sv
// Random and directed line transfers driven into two responder configurations,
// checked every cycle against a beat-schedule reference model.
module tb_l2_line_responder;
    import l2_line_responder_pkg::*;

    localparam int W   = 4;
    localparam int L0  = 2;
    localparam int L1  = 1;
    localparam int MW0 = 1024;
    localparam int MW1 = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              v = 1'b0;
    memory_operation_e ty = NOP;
    logic [31:0]       addr = '0;
    logic [31:0]       sw = '0;
    logic [31:0]       word0, word1;
    logic              val0, val1, ack0, ack1, busy0, busy1;

    l2_line_responder #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(W), .MEM_WORDS(MW0), .LATENCY(L0)) dut0 (
        .clk(clk), .reset(rst_n), .l2_req_valid(v), .l2_req_type(ty), .l2_req_address(addr),
        .l2_req_store_word(sw), .l2_fetched_word(word0), .l2_fetched_word_valid(val0),
        .l2_store_word_ack(ack0), .busy(busy0));

    l2_line_responder #(.ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(W), .MEM_WORDS(MW1), .LATENCY(L1)) dut1 (
        .clk(clk), .reset(rst_n), .l2_req_valid(v), .l2_req_type(ty), .l2_req_address(addr),
        .l2_req_store_word(sw), .l2_fetched_word(word1), .l2_fetched_word_valid(val1),
        .l2_store_word_ack(ack1), .busy(busy1));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    endtask

    // Reference model: st 0=idle, 1=transferring, 2=holding after the last beat.
    // t is the cycle number counted from the cycle the request was accepted in.
    int                m_st[2];
    int                m_t[2];
    memory_operation_e m_op[2];
    logic [31:0]       m_base[2];
    logic              m_ev[2], m_ea[2];
    logic [31:0]       m_ew[2];
    int                m_widx[2];
    logic [31:0]       m_mem[2][MW0];

    initial begin
        int lat, mw, idx, wi;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                lat = (d == 1) ? L1 : L0;
                mw  = (d == 1) ? MW1 : MW0;
                if (!rst_n) begin
                    m_st[d] = 0; m_ev[d] = 1'b0; m_ea[d] = 1'b0; m_ew[d] = '0;
                end else begin
                    if (m_ea[d]) m_mem[d][m_widx[d]] = sw;
                    m_ev[d] = 1'b0;
                    m_ea[d] = 1'b0;
                    case (m_st[d])
                        0: if (v && (ty == LOAD || ty == STORE)) begin
                            m_st[d] = 1; m_op[d] = ty; m_base[d] = addr & 32'hFFFF_FFF0; m_t[d] = 1;
                        end
                        1: if (!v) m_st[d] = 0;
                           else if (m_t[d] == lat * W) m_st[d] = 2;
                           else m_t[d]++;
                        default: if (!v || ty != m_op[d] || (addr & 32'hFFFF_FFF0) != m_base[d]) m_st[d] = 0;
                    endcase
                    if (m_st[d] == 1 && (m_t[d] % lat) == 0) begin
                        idx = W - 1 - (m_t[d] / lat - 1);
                        wi  = int'(((m_base[d] >> 2) + 32'(idx)) % 32'(mw));
                        if (m_op[d] == LOAD) begin
                            m_ev[d] = 1'b1; m_ew[d] = m_mem[d][wi];
                        end else begin
                            m_ea[d] = 1'b1; m_widx[d] = wi;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("d0 valid", val0, m_ev[0]);
            chk("d0 ack",   ack0, m_ea[0]);
            chk("d0 word",  word0, m_ew[0]);
            chk("d0 busy",  busy0, m_st[0] != 0);
            chk("d1 valid", val1, m_ev[1]);
            chk("d1 ack",   ack1, m_ea[1]);
            chk("d1 word",  word1, m_ew[1]);
            chk("d1 busy",  busy1, m_st[1] != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        sw = $urandom;
    endtask

    task automatic wait_release(input int bound);
        int   k;
        logic done;
        k = 0;
        done = 1'b0;
        while (!done && k < bound) begin
            step();
            k++;
            if (m_st[0] == 2 && m_st[1] == 2) done = 1'b1;
        end
        chk("release reached", done, 1'b1);
    endtask

    // mode 0: run then drop valid; 1: abort mid-line; 2: invalid type;
    // 3: type/address glitch mid-line then drop; 4: run then switch request while held.
    task automatic txn(input memory_operation_e op, input logic [31:0] a, input int mode);
        logic fresh;
        fresh = !v;
        v = 1'b1; ty = op; addr = a;
        if (mode == 1) begin
            repeat ($urandom_range(1, 9)) step();
            v = 1'b0; step(); step();
        end else if (mode == 2) begin
            ty = ($urandom_range(0, 1) == 1) ? memory_operation_e'(2'd3) : NOP;
            repeat (3) step();
            v = 1'b0; step();
        end else begin
            if (mode == 3 && fresh) begin
                step();
                ty = (op == LOAD) ? STORE : LOAD;
                addr = $urandom_range(0, 1023);
                step(); step();
                ty = op; addr = a;
            end
            wait_release(60);
            repeat ($urandom_range(0, 3)) step();
            if (mode == 4) begin
                ty = (op == LOAD) ? STORE : LOAD;
                addr = $urandom_range(0, 1023);
                step();
            end else begin
                v = 1'b0; step();
            end
        end
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 64; i++) txn(STORE, 32'(i * 16), 0);

        txn(STORE, 32'h40, 0);
        txn(LOAD,  32'h44, 0);
        txn(STORE, 32'h40, 4);
        txn(LOAD,  32'h80, 0);
        txn(LOAD,  32'h100, 0);
        txn(LOAD,  32'h3C, 0);
        txn(LOAD,  32'h7C, 0);
        txn(LOAD,  32'h20, 1);
        txn(NOP,   32'h0, 2);

        for (int i = 0; i < 200; i++)
            txn(($urandom_range(0, 1) == 1) ? STORE : LOAD, $urandom_range(0, 1023), $urandom_range(0, 4));

        // Reset in the middle of a STORE ack cycle.
        v = 1'b0; step(); step();
        v = 1'b1; ty = STORE; addr = 32'h80;
        k = 0;
        while (ack0 !== 1'b1 && k < 20) begin step(); k++; end
        chk("rst ack seen", ack0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst ack0 async",  ack0, 1'b0);
        chk("rst busy0 async", busy0, 1'b0);
        chk("rst ack1 async",  ack1, 1'b0);
        chk("rst busy1 async", busy1, 1'b0);
        chk("rst word0 async", word0, 32'h0);
        v = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        txn(LOAD, 32'h80, 0);
        txn(LOAD, 32'h84, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
